lcd_frame_scheduler: RTL and testbench
======================================

// Module: lcd_frame_scheduler
// PURPOSE
//  Sequences all traffic to the 8-bit ILI9341-style LCD write engine.
//  Shares the byte bus between two requesters: a host command port and a pixel stream.
//  On a frame request it waits for the tearing-effect (FMARK) edge, then emits the
//  window header (CASET/PASET/RAMWR) and streams WIDTH*HEIGHT RGB565 pixels, high byte first.
//  Sits between the host/pixel sources and the byte-level LCD write engine.
// PARAMETERS
//  WIDTH      320  pixels per line; CASET end value = WIDTH-1
//  HEIGHT     240  lines per frame; PASET end value = HEIGHT-1
//  TE_WAIT    1    1: frame start waits for FMARK rising edge; 0: starts immediately
// PORTS
//  i_clk          in   1   system clock
//  i_reset        in   1   asynchronous, active-high reset
//  i_frame_req    in   1   one-cycle pulse: request one full frame
//  i_cmd_valid    in   1   host byte valid
//  i_cmd_data     in   9   [8]=rs (0 cmd, 1 data), [7:0] byte
//  o_cmd_ready    out  1   host byte accepted when valid&ready
//  i_pix_valid    in   1   pixel valid
//  i_pix_data     in   16  RGB565 pixel
//  o_pix_ready    out  1   pixel accepted when valid&ready
//  i_lcd_fmark    in   1   LCD tearing-effect line (asynchronous)
//  o_bus_valid    out  1   byte to write engine valid
//  o_bus_rs       out  1   rs for current byte
//  o_bus_data     out  8   current byte
//  i_bus_ready    in   1   write engine accepts byte when valid&ready
//  o_busy         out  1   high in any state except IDLE
//  o_frame_done   out  1   one-cycle pulse after last pixel byte accepted
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; pending frame flag, counters, pixel register cleared.
//  Async reset mid-frame aborts immediately; no partial byte completes afterwards.
//  Bus handshake: o_bus_valid/rs/data are registered.
//  Once o_bus_valid=1 they hold stable until the cycle with i_bus_ready=1.
//  Next byte may be presented the cycle after acceptance (1 byte/cycle max).
//  FMARK: 2-flop synchronizer plus rising-edge detect (3 cycles after pin edge).
//  Edges outside WAIT_TE are ignored.
//  i_frame_req sets the pending flag in any state; a second request while pending/busy is merged.
//  States:
//   IDLE     o_cmd_ready=1 when no byte outstanding; an accepted cmd byte becomes the bus byte.
//            If pending and no cmd is in flight -> WAIT_TE (TE_WAIT=1) or HDR (TE_WAIT=0).
//            Clear pending on exit.
//            A cmd valid in the same cycle as pending wins; the frame starts after that byte is accepted.
//   WAIT_TE  -> HDR on synchronized FMARK rising edge.
//   HDR      11 bytes in order:
//            2A(rs0) 00 00 hi(W-1) lo(W-1) 2B(rs0) 00 00 hi(H-1) lo(H-1) 2C(rs0).
//            All others rs=1. After the 11th byte is accepted -> PIX_LD.
//   PIX_LD   o_pix_ready=1 when no byte outstanding; on accept latch pixel, present hi byte (rs=1) -> PIX_LO.
//   PIX_LO   After hi accepted present lo byte; after lo accepted:
//            if pixel count == WIDTH*HEIGHT-1 -> DONE, else count++ -> PIX_LD.
//   DONE     o_frame_done=1 for one cycle, count=0 -> IDLE.
//            A pending request raised during the frame starts the next frame from IDLE.
//  o_cmd_ready=0 outside IDLE; o_pix_ready=0 outside PIX_LD.
//  Pixel underrun (i_pix_valid=0) stalls in PIX_LD indefinitely; o_bus_valid=0 meanwhile.
//  Pixel counter is 17 bits, compared against WIDTH*HEIGHT-1 (76799 default); no wrap within a frame.
// TESTING
//  1 Reset, then cmd bytes 0x011(rs0), 0x129 with i_bus_ready=1 -> two bus bytes in order, rs 0,1; o_busy=0 throughout.
//  2 TE_WAIT=1, frame_req, no FMARK for 1000 cycles -> no bus bytes, o_busy=1;
//    FMARK rises -> header 2A 00 00 01 3F 2B 00 00 00 EF 2C within 4+11 cycles.
//  3 Full frame, pixel = index, random i_bus_ready/i_pix_valid -> 153600 bytes, MSB first.
//    o_frame_done pulses exactly once, after the final lo byte.
//  4 i_bus_ready held 0 for 20 cycles mid-header -> o_bus_valid/rs/data stable; no byte skipped or repeated.
//  5 cmd valid and frame_req in the same IDLE cycle -> cmd byte first, then frame; frame_req during frame -> second frame follows.
//  6 Assert i_reset mid-PIX_LO -> outputs 0 immediately.
//    After release, frame_req replays the full header from byte 0x2A.

Source files
------------

// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler: shares one registered byte bus between host command bytes and
// framed RGB565 pixel traffic (FMARK-synchronised window header plus pixel stream).
module lcd_frame_scheduler #(
  parameter int WIDTH   = 320,
  parameter int HEIGHT  = 240,
  parameter bit TE_WAIT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_frame_req,
  input  logic        i_cmd_valid,
  input  logic [8:0]  i_cmd_data,
  output logic        o_cmd_ready,
  input  logic        i_pix_valid,
  input  logic [15:0] i_pix_data,
  output logic        o_pix_ready,
  input  logic        i_lcd_fmark,
  output logic        o_bus_valid,
  output logic        o_bus_rs,
  output logic [7:0]  o_bus_data,
  input  logic        i_bus_ready,
  output logic        o_busy,
  output logic        o_frame_done
);
  localparam logic [15:0] W_END    = 16'(WIDTH - 1);
  localparam logic [15:0] H_END    = 16'(HEIGHT - 1);
  localparam logic [16:0] PIX_LAST = 17'(WIDTH * HEIGHT - 1);
  localparam logic [3:0]  HDR_LAST = 4'd10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_TE = 3'd1,
    HDR     = 3'd2,
    PIX_LD  = 3'd3,
    PIX_LO  = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Window header byte {rs, data} for position idx: CASET, PASET, then RAMWR.
  function automatic logic [8:0] hdr_byte(input logic [3:0] idx);
    logic [8:0] b;
    case (idx)
      4'd0:    b = {1'b0, 8'h2A};
      4'd1:    b = {1'b1, 8'h00};
      4'd2:    b = {1'b1, 8'h00};
      4'd3:    b = {1'b1, W_END[15:8]};
      4'd4:    b = {1'b1, W_END[7:0]};
      4'd5:    b = {1'b0, 8'h2B};
      4'd6:    b = {1'b1, 8'h00};
      4'd7:    b = {1'b1, 8'h00};
      4'd8:    b = {1'b1, H_END[15:8]};
      4'd9:    b = {1'b1, H_END[7:0]};
      4'd10:   b = {1'b0, 8'h2C};
      default: b = {1'b0, 8'h00};
    endcase
    return b;
  endfunction

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_rs_q, bus_rs_d;
  logic [7:0]  bus_data_q, bus_data_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        pix_ready_q, pix_ready_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic [3:0]  hdr_idx_q, hdr_idx_d;
  logic [16:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]  pix_lo_q, pix_lo_d;
  logic        lo_sent_q, lo_sent_d;
  logic        fm_meta_q, fm_meta_d;
  logic        fm_sync_q, fm_sync_d;
  logic        fm_prev_q, fm_prev_d;
  logic        fm_rise_q, fm_rise_d;
  logic        bus_accept_s;

  // Next-state and next-output computation for the whole scheduler.
  always_comb begin
    bus_accept_s = bus_valid_q & i_bus_ready;
    state_d      = state_q;
    pend_d       = pend_q | i_frame_req;
    bus_valid_d  = bus_valid_q;
    bus_rs_d     = bus_rs_q;
    bus_data_d   = bus_data_q;
    frame_done_d = 1'b0;
    hdr_idx_d    = hdr_idx_q;
    pix_cnt_d    = pix_cnt_q;
    pix_lo_d     = pix_lo_q;
    lo_sent_d    = lo_sent_q;
    fm_meta_d    = i_lcd_fmark;
    fm_sync_d    = fm_meta_q;
    fm_prev_d    = fm_sync_q;
    fm_rise_d    = fm_sync_q & ~fm_prev_q;

    case (state_q)
      IDLE: begin
        // A valid host byte beats a pending frame; the frame leaves only from an empty bus.
        if (bus_accept_s) begin
          bus_valid_d = 1'b0;
        end else if (cmd_ready_q && i_cmd_valid) begin
          bus_valid_d = 1'b1;
          bus_rs_d    = i_cmd_data[8];
          bus_data_d  = i_cmd_data[7:0];
        end else if (cmd_ready_q && pend_q) begin
          pend_d    = 1'b0;
          hdr_idx_d = 4'd0;
          if (TE_WAIT) begin
            state_d = WAIT_TE;
          end else begin
            state_d                = HDR;
            bus_valid_d            = 1'b1;
            {bus_rs_d, bus_data_d} = hdr_byte(4'd0);
          end
        end else begin
          bus_valid_d = bus_valid_q;
        end
      end
      WAIT_TE: begin
        if (fm_rise_q) begin
          state_d                = HDR;
          hdr_idx_d              = 4'd0;
          bus_valid_d            = 1'b1;
          {bus_rs_d, bus_data_d} = hdr_byte(4'd0);
        end else begin
          state_d = WAIT_TE;
        end
      end
      HDR: begin
        if (bus_accept_s) begin
          if (hdr_idx_q == HDR_LAST) begin
            state_d     = PIX_LD;
            bus_valid_d = 1'b0;
          end else begin
            hdr_idx_d              = hdr_idx_q + 4'd1;
            {bus_rs_d, bus_data_d} = hdr_byte(hdr_idx_q + 4'd1);
          end
        end else begin
          state_d = HDR;
        end
      end
      PIX_LD: begin
        if (pix_ready_q && i_pix_valid) begin
          state_d     = PIX_LO;
          bus_valid_d = 1'b1;
          bus_rs_d    = 1'b1;
          bus_data_d  = i_pix_data[15:8];
          pix_lo_d    = i_pix_data[7:0];
          lo_sent_d   = 1'b0;
        end else begin
          state_d = PIX_LD;
        end
      end
      PIX_LO: begin
        if (bus_accept_s) begin
          if (!lo_sent_q) begin
            bus_rs_d   = 1'b1;
            bus_data_d = pix_lo_q;
            lo_sent_d  = 1'b1;
          end else begin
            bus_valid_d = 1'b0;
            lo_sent_d   = 1'b0;
            if (pix_cnt_q == PIX_LAST) begin
              state_d      = DONE;
              frame_done_d = 1'b1;
            end else begin
              state_d   = PIX_LD;
              pix_cnt_d = pix_cnt_q + 17'd1;
            end
          end
        end else begin
          state_d = PIX_LO;
        end
      end
      DONE: begin
        state_d   = IDLE;
        pix_cnt_d = 17'd0;
      end
      default: begin
        state_d     = IDLE;
        bus_valid_d = 1'b0;
      end
    endcase

    // Ready strobes are registered, so they look one cycle ahead at the next state.
    cmd_ready_d = (state_d == IDLE) && !bus_valid_d;
    pix_ready_d = (state_d == PIX_LD) && !bus_valid_d;
    busy_d      = (state_d != IDLE);
  end

  // State, output and synchroniser registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_rs_q     <= 1'b0;
      bus_data_q   <= 8'h00;
      cmd_ready_q  <= 1'b0;
      pix_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      hdr_idx_q    <= 4'd0;
      pix_cnt_q    <= 17'd0;
      pix_lo_q     <= 8'h00;
      lo_sent_q    <= 1'b0;
      fm_meta_q    <= 1'b0;
      fm_sync_q    <= 1'b0;
      fm_prev_q    <= 1'b0;
      fm_rise_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      bus_valid_q  <= bus_valid_d;
      bus_rs_q     <= bus_rs_d;
      bus_data_q   <= bus_data_d;
      cmd_ready_q  <= cmd_ready_d;
      pix_ready_q  <= pix_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      hdr_idx_q    <= hdr_idx_d;
      pix_cnt_q    <= pix_cnt_d;
      pix_lo_q     <= pix_lo_d;
      lo_sent_q    <= lo_sent_d;
      fm_meta_q    <= fm_meta_d;
      fm_sync_q    <= fm_sync_d;
      fm_prev_q    <= fm_prev_d;
      fm_rise_q    <= fm_rise_d;
    end
  end

  assign o_cmd_ready  = cmd_ready_q;
  assign o_pix_ready  = pix_ready_q;
  assign o_bus_valid  = bus_valid_q;
  assign o_bus_rs     = bus_rs_q;
  assign o_bus_data   = bus_data_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Scoreboard bench for lcd_frame_scheduler: expected bus bytes and frame-done markers are
// queued by the stimulus, a monitor pops them as the DUT hands bytes to the write engine.
module tb_lcd_frame_scheduler;
  localparam int TW    = 320;
  localparam int TH    = 2;
  localparam int TOTAL = TW * TH;
  localparam logic [9:0] DONE_MARK = 10'h200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_frame_req, i_cmd_valid, i_pix_valid, i_lcd_fmark, i_bus_ready;
  logic [8:0]  i_cmd_data;
  logic [15:0] i_pix_data;
  logic        o_cmd_ready, o_pix_ready, o_bus_valid, o_bus_rs, o_busy, o_frame_done;
  logic [7:0]  o_bus_data;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         popped = 0;
  int         n_done = 0;
  int         pix_idx = 0;
  int         rdy_mode = 1;
  bit         pix_on = 1'b0;
  bit         fm_auto = 1'b0;
  bit         fm_man = 1'b0;
  bit         chk_idle = 1'b0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_frame_scheduler #(.WIDTH(TW), .HEIGHT(TH), .TE_WAIT(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_frame_req(i_frame_req),
    .i_cmd_valid(i_cmd_valid), .i_cmd_data(i_cmd_data), .o_cmd_ready(o_cmd_ready),
    .i_pix_valid(i_pix_valid), .i_pix_data(i_pix_data), .o_pix_ready(o_pix_ready),
    .i_lcd_fmark(i_lcd_fmark), .o_bus_valid(o_bus_valid), .o_bus_rs(o_bus_rs),
    .o_bus_data(o_bus_data), .i_bus_ready(i_bus_ready), .o_busy(o_busy),
    .o_frame_done(o_frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: window header from the frame size, then pixel i as hi/lo bytes.
  task automatic push_frame();
    logic [15:0] we, he, p;
    we = 16'(TW - 1);
    he = 16'(TH - 1);
    exp_q.push_back(10'h02A);
    exp_q.push_back(10'h100);
    exp_q.push_back(10'h100);
    exp_q.push_back({2'b01, we[15:8]});
    exp_q.push_back({2'b01, we[7:0]});
    exp_q.push_back(10'h02B);
    exp_q.push_back(10'h100);
    exp_q.push_back(10'h100);
    exp_q.push_back({2'b01, he[15:8]});
    exp_q.push_back({2'b01, he[7:0]});
    exp_q.push_back(10'h02C);
    for (int i = 0; i < TOTAL; i++) begin
      p = 16'(i);
      exp_q.push_back({2'b01, p[15:8]});
      exp_q.push_back({2'b01, p[7:0]});
    end
    exp_q.push_back(DONE_MARK);
  endtask

  task automatic req_frame();
    @(negedge clk);
    i_frame_req = 1'b1;
    push_frame();
    @(negedge clk);
    i_frame_req = 1'b0;
  endtask

  task automatic send_cmd(input logic [8:0] v);
    int n;
    n = 0;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_data  = v;
    #2;
    while (!o_cmd_ready && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("cmd_accept", 32'(n < 200), 32'd1);
    exp_q.push_back({1'b0, v});
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_popped(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (popped < target && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    check(name, 32'(popped >= target), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    #3;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Input driver: bus-ready pattern, random pixel source, FMARK pin.
  initial begin
    int fm_cnt;
    fm_cnt      = 0;
    i_bus_ready = 1'b0;
    i_pix_valid = 1'b0;
    i_pix_data  = 16'h0000;
    i_lcd_fmark = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       i_bus_ready = 1'($urandom_range(0, 1));
        1:       i_bus_ready = 1'b1;
        default: i_bus_ready = 1'b0;
      endcase
      i_pix_valid = pix_on && ($urandom_range(0, 1) == 1);
      i_pix_data  = 16'(pix_idx);
      fm_cnt++;
      i_lcd_fmark = fm_auto ? ((fm_cnt % 40) < 5) : fm_man;
    end
  end

  // Monitor: pops the scoreboard on every accepted byte and every frame-done pulse.
  initial begin
    logic       prev_stall;
    logic [8:0] prev_byte;
    logic [9:0] e;
    prev_stall = 1'b0;
    prev_byte  = 9'h000;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("bus_hold", 32'({o_bus_valid, o_bus_rs, o_bus_data}), 32'({1'b1, prev_byte}));
        if (chk_idle)
          check("busy_low", 32'(o_busy), 32'd0);
        if (o_bus_valid && i_bus_ready) begin
          popped++;
          if (exp_q.size() == 0) begin
            check("bus_unexpected", 32'({o_bus_rs, o_bus_data}), 32'h3FF);
          end else begin
            e = exp_q.pop_front();
            check("bus_byte", 32'({1'b0, o_bus_rs, o_bus_data}), 32'(e));
          end
        end
        if (o_frame_done) begin
          n_done++;
          if (exp_q.size() == 0) begin
            check("done_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("frame_done", 32'(DONE_MARK), 32'(e));
          end
        end
        if (o_pix_ready && i_pix_valid)
          pix_idx = (pix_idx + 1 == TOTAL) ? 0 : pix_idx + 1;
        prev_stall = o_bus_valid && !i_bus_ready;
        prev_byte  = {o_bus_rs, o_bus_data};
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    i_frame_req = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_data  = 9'h000;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 32'({o_cmd_ready, o_pix_ready, o_bus_valid, o_bus_rs, o_bus_data,
                                o_busy, o_frame_done}), 32'd0);
    rst = 1'b0;

    // Host command bytes pass straight through while idle.
    chk_idle = 1'b1;
    send_cmd(9'h011);
    send_cmd(9'h129);
    repeat (4) @(negedge clk);
    chk_idle = 1'b0;
    #3;
    check("t1_bytes", 32'(popped), 32'd2);

    // Frame parks in WAIT_TE until FMARK rises, then the header follows within 4+11 cycles.
    req_frame();
    repeat (1000) @(negedge clk);
    #3;
    check("t2_busy_wait", 32'(o_busy), 32'd1);
    check("t2_no_bytes", 32'(popped), 32'd2);
    fm_man = 1'b1;
    repeat (15) @(negedge clk);
    #3;
    check("t2_header_time", 32'(popped), 32'd13);
    check("t2_left", 32'(exp_q.size()), 32'(2 * TOTAL + 1));

    // Random bus/pixel handshakes for the rest of the frame.
    fm_man   = 1'b0;
    fm_auto  = 1'b1;
    rdy_mode = 0;
    pix_on   = 1'b1;
    wait_drain("t3_drain", 20000);
    check("t3_done_count", 32'(n_done), 32'd1);

    // Back-pressure in the middle of the header.
    p0 = popped;
    req_frame();
    wait_popped("t4_reach_hdr", p0 + 3, 2000);
    rdy_mode = 2;
    p0 = popped;
    repeat (20) @(negedge clk);
    #3;
    check("t4_valid_held", 32'(o_bus_valid), 32'd1);
    check("t4_no_accept", 32'(popped), 32'(p0));
    rdy_mode = 0;
    wait_drain("t4_drain", 20000);
    check("t4_done_count", 32'(n_done), 32'd2);

    // Command and frame request in the same idle cycle, then a request during the frame.
    repeat (3) @(negedge clk);
    p0 = popped;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_data  = 9'h036;
    i_frame_req = 1'b1;
    exp_q.push_back(10'h036);
    push_frame();
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_frame_req = 1'b0;
    wait_popped("t5_mid_frame", p0 + 200, 5000);
    req_frame();
    wait_drain("t5_drain", 30000);
    check("t5_done_count", 32'(n_done), 32'd4);

    // Reset while a pixel byte is on the bus, then a clean frame from the first header byte.
    p0 = popped;
    req_frame();
    wait_popped("t6_reach_pix", p0 + 41, 5000);
    begin
      int n;
      n = 0;
      while (!o_bus_valid && n < 100) begin
        @(negedge clk);
        #3;
        n++;
      end
    end
    rst = 1'b1;
    #1;
    check("t6_reset_outputs", 32'({o_cmd_ready, o_pix_ready, o_bus_valid, o_bus_rs, o_bus_data,
                                   o_busy, o_frame_done}), 32'd0);
    exp_q.delete();
    pix_idx = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    p0 = n_done;
    req_frame();
    wait_drain("t6_drain", 20000);
    check("t6_done_count", 32'(n_done - p0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
